main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Main-memory side of the cache-to-memory interface: the responder that services block-read and word-write requests from the cache controller.
- Backing store is a single-port array of 32-bit words, reached through a fixed access latency.
- A read miss is answered with a full 512-bit, 16-word block assembled one word per cycle; a write-through updates one word.
- Sits between the cache controller and the memory model; also serves as the memory model for system benches.

Parameters:
ADDR_WORDS_LOG2, 12, log2 of array depth in 32-bit words (4..30); 12 = 16 KB
LATENCY, 4, initial access latency in cycles (1..255), 8-bit counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_addr  input  32  byte address; read uses [31:6] (block aligned), write uses [31:2]
mem_wdata  input  32  write word
mem_read_req  input  1  block read request, one-cycle pulse
mem_write_req  input  1  word write request, one-cycle pulse
mem_rdata  output  512  assembled block; word i in bits [i*32+:32]
mem_ready  output  1  one-cycle completion pulse
busy  output  1  high while a request is in progress (state != IDLE)
protocol_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (asynchronous, rst_n low):
  - FSM to IDLE; mem_rdata=0, mem_ready=0, busy=0, protocol_err=0; latency and beat counters cleared.
  - Array contents are not reset and are preserved. Any in-flight write is not committed.
  - Locations never written read as X.
- Array index = addr[ADDR_WORDS_LOG2+1:2]; address bits above this are ignored, so addresses alias modulo 2^ADDR_WORDS_LOG2 words.
- States: IDLE, WAIT, BURST, WRITE, RESP.
- IDLE: a request is accepted when its pulse is sampled at edge E0 (the request is high in cycle 0).
  - Address and data are latched. Read latches blk = addr[31:6] with beat = 0.
  - LATENCY is loaded into the counter; next state is WAIT.
- WAIT: occupies cycles 1..LATENCY; the counter decrements each cycle. On expiry the FSM goes to BURST (read) or WRITE (write).
- BURST: occupies cycles LATENCY+1..LATENCY+16.
  - Each cycle reads word {blk, beat} into mem_rdata[beat*32+:32], then increments beat.
  - After beat 15 the FSM goes to RESP.
  - The beat counter is 4 bits and wraps only at completion.
- WRITE: occupies cycle LATENCY+1. The word is written at the edge ending this cycle, mem_ready is high during this cycle, and the next state is IDLE.
- RESP (read only): mem_ready is high in cycle LATENCY+17; next state is IDLE.
  - mem_rdata is complete and stable in the ready cycle.
  - mem_rdata holds until the first BURST beat of the next read.
  - Partial updates of mem_rdata are visible during BURST; the consumer samples only on mem_ready.
- Total latency, measured from the request cycle to the mem_ready cycle:
  - read: LATENCY+17;
  - write: LATENCY+1.
- mem_ready is never high for more than one cycle, and never in the cycle after a request.
- busy is high from cycle 1 through the mem_ready cycle inclusive.
- A new request may be accepted in the cycle after mem_ready, since the FSM is then back in IDLE.
- Boundary conditions:
  - Read and write requests high in the same IDLE cycle: the read is serviced, the write is dropped, and protocol_err is set.
  - Any request pulse while busy=1 (including the mem_ready cycle) is ignored and sets protocol_err; the in-flight operation completes on its original schedule.
  - protocol_err is cleared only by reset.
  - A request held high for more than one cycle counts as a new request once the FSM is back in IDLE; the controller is expected to pulse.
- mem_wdata and mem_addr are ignored outside the accepting IDLE cycle.

Test Plan:
All scenarios use LATENCY=4 and ADDR_WORDS_LOG2=12.
- Write 0xDEADBEEF to 0x0000_0048 in cycle 0 -> busy cycles 1..5; mem_ready high in cycle 5 only; a later read of block 0x40 returns word 2 = 0xDEADBEEF.
- Write 0x1000+i to 0x40+4i for i=0..15, then read with mem_addr=0x0000_0053 -> mem_ready in cycle 21 after the request; mem_rdata[i*32+:32]=0x1000+i; mem_rdata unchanged for 10 cycles afterwards.
- Read and write requests both high in one cycle (write data 0x5555_5555 to 0x44) -> block read completes at cycle 21; word 1 keeps its old value; protocol_err=1 until reset.
- Second read pulse in cycle 3 of an active read -> ignored; the first read's mem_ready still arrives at cycle 21; only one mem_ready pulse; protocol_err=1.
- rst_n low in cycle 10 of a read (during BURST) -> mem_rdata=0, mem_ready=0, busy=0 immediately; after release, a fresh read of block 0x40 completes at LATENCY+17 with correct data.
- Write 0xCAFEF00D to 0x0000_4048 (aliases word index 0x12) -> read of block 0x40 returns word 2 = 0xCAFEF00D.

Source files
------------

// File: rtl/main_mem_responder.sv
// Main-memory responder for the cache-to-memory interface.
// It services 16-word block reads and single-word writes against a word array,
// with a fixed access latency in front of every operation.
module main_mem_responder #(
    parameter int ADDR_WORDS_LOG2 = 12,
    parameter int LATENCY         = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_wdata,
    input  logic         mem_read_req,
    input  logic         mem_write_req,
    output logic [511:0] mem_rdata,
    output logic         mem_ready,
    output logic         busy,
    output logic         protocol_err
);

    localparam int DEPTH = 1 << ADDR_WORDS_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [7:0]                   r_lat;
    logic [3:0]                   r_beat;
    logic                         r_is_rd;
    logic [ADDR_WORDS_LOG2-1:0]   r_widx;
    logic [31:0]                  r_wdata;
    logic [511:0]                 r_rdata;
    logic                         r_err;
    logic [31:0]                  r_mem [DEPTH];

    logic                         w_idle;
    logic                         w_accept;
    logic                         w_accept_rd;
    logic                         w_violation;
    logic [ADDR_WORDS_LOG2-1:0]   w_idx_in;
    logic [ADDR_WORDS_LOG2-1:0]   w_rd_idx;
    logic                         w_unused_addr;

    assign w_idle      = (r_state == S_IDLE);
    // A read wins over a simultaneous write; the write is dropped.
    assign w_accept_rd = w_idle && mem_read_req;
    assign w_accept    = w_idle && (mem_read_req || mem_write_req);
    assign w_violation = (w_idle && mem_read_req && mem_write_req) ||
                         (!w_idle && (mem_read_req || mem_write_req));

    // Word index; address bits above the array depth alias.
    assign w_idx_in = mem_addr[ADDR_WORDS_LOG2+1:2];
    // Reads latch a block-aligned index, so the beat can simply be OR-ed in.
    assign w_rd_idx = r_widx | ADDR_WORDS_LOG2'(r_beat);
    // Byte-offset and aliased high address bits are intentionally ignored.
    assign w_unused_addr = ^mem_addr;

    assign mem_rdata    = r_rdata;
    assign mem_ready    = (r_state == S_WRITE) || (r_state == S_RESP);
    assign busy         = !w_idle;
    assign protocol_err = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (mem_read_req || mem_write_req) w_next = S_WAIT;
            S_WAIT:  if (r_lat == 8'd1) w_next = r_is_rd ? S_BURST : S_WRITE;
            S_BURST: if (r_beat == 4'd15) w_next = S_RESP;
            S_WRITE: w_next = S_IDLE;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Latency and beat counters, block assembly and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat   <= 8'd0;
            r_beat  <= 4'd0;
            r_is_rd <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_lat   <= 8'(LATENCY);
                r_beat  <= 4'd0;
                r_is_rd <= w_accept_rd;
            end else if (r_state == S_WAIT) begin
                r_lat <= r_lat - 8'd1;
            end
            if (r_state == S_BURST) begin
                r_rdata[{r_beat, 5'd0} +: 32] <= r_mem[w_rd_idx];
                r_beat                        <= r_beat + 4'd1;
            end
            if (w_violation) begin
                r_err <= 1'b1;
            end
        end
    end

    // Request address and write data, captured only when a request is accepted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_widx  <= w_accept_rd ? (w_idx_in & ~ADDR_WORDS_LOG2'(15)) : w_idx_in;
            r_wdata <= mem_wdata;
        end
    end

    // Array write at the end of the WRITE cycle; a reset leaves WRITE first, so no commit.
    always_ff @(posedge clk) begin
        if (r_state == S_WRITE) begin
            r_mem[r_widx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: a cycle-level behavioural model
// of the request schedule and word memory, compared on every falling edge.
module tb_main_mem_responder;

    localparam int L  = 4;
    localparam int AW = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_read_req;
    logic         mem_write_req;
    logic [511:0] mem_rdata;
    logic         mem_ready;
    logic         busy;
    logic         protocol_err;

    always #5 clk = ~clk;

    main_mem_responder #(.ADDR_WORDS_LOG2(AW), .LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
        .protocol_err(protocol_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state: one outstanding operation described by its accept and ready cycles.
    bit           m_active;
    bit           m_is_rd;
    bit           m_err;
    int           m_acc;
    int           m_rdy;
    int           m_widx;
    int           m_base;
    logic [31:0]  m_wd;
    logic [511:0] m_rdata;
    logic [511:0] m_mask;
    logic [31:0]  m_mem [0:(1<<AW)-1];
    bit           m_vld [0:(1<<AW)-1];

    int ready_cnt  = 0;
    int last_ready = -1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_err    = 1'b0;
        m_rdata  = '0;
        m_mask   = '1;
    endtask

    // Advances the model over the edge that ends cycle cyc, using this cycle's inputs.
    task automatic model_update();
        int c;
        c = cyc;
        if (rst_n) begin
            if (m_active && !m_is_rd && c == m_rdy) begin
                m_mem[m_widx] = m_wd;
                m_vld[m_widx] = 1'b1;
            end
            if (m_active && c > m_acc && c <= m_rdy) begin
                if (mem_read_req || mem_write_req) m_err = 1'b1;
            end else if (mem_read_req || mem_write_req) begin
                m_active = 1'b1;
                m_acc    = c;
                m_is_rd  = mem_read_req;
                m_rdy    = c + L + (mem_read_req ? 17 : 1);
                m_widx   = int'(mem_addr[AW+1:2]);
                m_base   = int'(mem_addr[AW+1:6]) * 16;
                m_wd     = mem_wdata;
                if (mem_read_req && mem_write_req) m_err = 1'b1;
            end
        end
        cyc = c + 1;
        if (rst_n && m_active && m_is_rd && cyc == m_rdy) begin
            for (int w = 0; w < 16; w++) begin
                if (m_vld[m_base + w]) begin
                    m_rdata[w*32 +: 32] = m_mem[m_base + w];
                    m_mask[w*32 +: 32]  = '1;
                end else begin
                    m_rdata[w*32 +: 32] = '0;
                    m_mask[w*32 +: 32]  = '0;
                end
            end
        end
    endtask

    task automatic tick(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        mem_read_req  = rd;
        mem_write_req = wr;
        mem_addr      = a;
        mem_wdata     = d;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom, $urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the model.
    initial begin
        logic exp_busy;
        logic exp_ready;
        bit   in_burst;
        forever begin
            @(negedge clk);
            exp_busy  = rst_n && m_active && cyc > m_acc && cyc <= m_rdy;
            exp_ready = rst_n && m_active && cyc == m_rdy;
            in_burst  = rst_n && m_active && m_is_rd && cyc > m_acc + L + 1 && cyc < m_rdy;
            chk("busy", 512'(busy), 512'(exp_busy));
            chk("mem_ready", 512'(mem_ready), 512'(exp_ready));
            chk("protocol_err", 512'(protocol_err), 512'(m_err));
            if (!in_burst) chk("mem_rdata", mem_rdata & m_mask, m_rdata & m_mask);
            if (mem_ready) begin
                ready_cnt++;
                last_ready = cyc;
            end
        end
    end

    initial begin
        int c0;
        logic [31:0] a;
        for (int i = 0; i < (1 << AW); i++) m_vld[i] = 1'b0;
        mem_read_req  = 1'b0;
        mem_write_req = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        rst_n         = 1'b0;
        model_reset();
        #1;
        chk("reset_busy", 512'(busy), 512'(0));
        chk("reset_ready", 512'(mem_ready), 512'(0));
        chk("reset_rdata", mem_rdata, 512'(0));
        chk("reset_err", 512'(protocol_err), 512'(0));
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Single write then read-back of its block.
        c0 = cyc;
        tick(1'b1 == 1'b0, 1'b1, 32'h0000_0048, 32'hDEAD_BEEF);
        idle(8);
        chk("wr_ready_cycle", 512'(last_ready), 512'(c0 + 5));
        c0 = cyc;
        tick(1'b1, 1'b0, 32'h0000_0040, $urandom);
        idle(24);
        chk("rd_ready_cycle", 512'(last_ready), 512'(c0 + 21));
        chk("rd_word2", 512'(mem_rdata[2*32 +: 32]), 512'(32'hDEAD_BEEF));
        chk("model_word2", 512'(m_rdata[2*32 +: 32]), 512'(32'hDEAD_BEEF));

        // Fill a block with back-to-back writes, then read with an unaligned address.
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'h1000 + 32'(i));
            idle(5);
        end
        c0 = cyc;
        tick(1'b1, 1'b0, 32'h0000_0053, $urandom);
        idle(31);
        chk("blk_ready_cycle", 512'(last_ready), 512'(c0 + 21));
        chk("blk_word0", 512'(mem_rdata[0 +: 32]), 512'(32'h1000));
        chk("blk_word9", 512'(mem_rdata[9*32 +: 32]), 512'(32'h1009));
        chk("blk_word15", 512'(mem_rdata[15*32 +: 32]), 512'(32'h100F));

        // Read and write together: read serviced, write dropped, error sticks.
        c0 = cyc;
        tick(1'b1, 1'b1, 32'h0000_0044, 32'h5555_5555);
        idle(24);
        chk("rw_ready_cycle", 512'(last_ready), 512'(c0 + 21));
        chk("rw_word1_kept", 512'(mem_rdata[1*32 +: 32]), 512'(32'h1001));
        chk("rw_err", 512'(protocol_err), 512'(1));
        do_reset();
        chk("err_cleared", 512'(protocol_err), 512'(0));

        // Second read pulse while busy is ignored.
        ready_cnt = 0;
        c0 = cyc;
        tick(1'b1, 1'b0, 32'h0000_0040, $urandom);
        idle(2);
        tick(1'b1, 1'b0, 32'h0000_0080, $urandom);
        idle(24);
        chk("busy_req_ready_cycle", 512'(last_ready), 512'(c0 + 21));
        chk("busy_req_one_ready", 512'(ready_cnt), 512'(1));
        chk("busy_req_err", 512'(protocol_err), 512'(1));
        do_reset();

        // Reset in the middle of a burst.
        c0 = cyc;
        tick(1'b1, 1'b0, 32'h0000_0040, $urandom);
        idle(9);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_busy", 512'(busy), 512'(0));
        chk("midrst_ready", 512'(mem_ready), 512'(0));
        chk("midrst_rdata", mem_rdata, 512'(0));
        #3;
        idle(2);
        rst_n = 1'b1;
        c0 = cyc;
        tick(1'b1, 1'b0, 32'h0000_0040, $urandom);
        idle(24);
        chk("postrst_ready_cycle", 512'(last_ready), 512'(c0 + 21));
        chk("postrst_word4", 512'(mem_rdata[4*32 +: 32]), 512'(32'h1004));

        // Aliased write address lands in block 0x40.
        tick(1'b0, 1'b1, 32'h0000_4048, 32'hCAFE_F00D);
        idle(5);
        tick(1'b1, 1'b0, 32'h0000_0040, $urandom);
        idle(24);
        chk("alias_word2", 512'(mem_rdata[2*32 +: 32]), 512'(32'hCAFE_F00D));
        do_reset();

        // Randomized traffic over a few blocks with aliased high bits.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 3)) << 6) |
                (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            tick(r < 12 || r == 99, (r >= 12 && r < 30) || r == 99, a, $urandom);
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
